reg_file_v1: RTL and testbench
==============================

# reg_file_v1

Register-file responder for the instruction decoder's operand-read protocol (`rs_addr`, `rs_valid`, `rs_sel`, `rs_store`, `rd_addr`). It holds the 32 architectural registers and returns operand A, then operand B, to the ALU. It then waits for the ALU write-back and commits the result to the destination register that was latched when operand A was read. It sits between the decoder (request side) and the ALU (operand consumer and write-back producer).

## Interface
- `XLEN`, 32, register and operand width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `rs_addr`  in  5  source register index for the current read cycle.
- `rs_valid`  in  1  read-request strobe; one operand phase per high cycle.
- `rs_sel`  in  1  0 = operand-A or immediate phase, 1 = operand-B (rs2) phase.
- `rs_store`  in  1  memory-op tag; sampled on the operand-A phase.
- `rd_addr`  in  5  destination index; sampled on the operand-A phase.
- `wb_valid`  in  1  ALU write-back strobe.
- `wb_data`  in  XLEN  write-back value.
- `op_a`  out  XLEN  registered operand A.
- `op_b`  out  XLEN  registered operand B; 0 for immediate instructions.
- `ops_valid`  out  1  both operand phases are complete; ALU may consume.
- `mem_op`  out  1  latched `rs_store` of the current instruction.
- `protocol_err`  out  1  sticky protocol-violation flag.

## Operation
- Storage: 32 × XLEN registers. Index 0 always reads 0, and writes to it are discarded.
- FSM states:
  - S_IDLE
    - On `rs_valid && !rs_sel`: capture `op_a = R[rs_addr]`, `rd_lat = rd_addr`, `mem_op = rs_store`, and clear `op_b` to 0. Go to S_HAVE_A.
    - On `rs_valid && rs_sel`: set `protocol_err`, ignore the request, stay in S_IDLE.
  - S_HAVE_A
    - On `rs_valid && rs_sel`: `op_b = R[rs_addr]`. Go to S_WAIT_WB.
    - On `rs_valid && !rs_sel`: this is the immediate phase. `op_b` stays 0 and `op_a` is not overwritten, even though the decoder drives `rs_addr = 0` in this phase. Go to S_WAIT_WB.
    - With `rs_valid` low: hold state.
  - S_WAIT_WB
    - `ops_valid` = 1 in this state.
    - On `wb_valid`: write `R[rd_lat] = wb_data` (skipped if `rd_lat` = 0), then go to S_IDLE.
    - On `rs_valid`: set `protocol_err` and ignore the request.
- In any state other than S_WAIT_WB, `wb_valid` sets `protocol_err` and no register is written.
- `op_a`, `op_b` and `mem_op` hold their values until the next operand-A capture.
- `ops_valid` is a registered output decoded from the state.

## Timing
- Reset values:
  - All 32 registers are 0.
  - `op_a`, `op_b` = 0.
  - `ops_valid`, `mem_op`, `protocol_err` = 0.
  - FSM state = S_IDLE.
  - `rd_lat` = 0.
- Reads are synchronous. Data is sampled at the edge where `rs_valid` is high and appears on `op_a`/`op_b` the following cycle.
- Decoder sequence, with RS1 phase in cycle T and RS2/IMME phase in T+1:
  - `op_a` is valid from T+1.
  - `op_b` and `ops_valid` are valid from T+2, aligned with the decoder's EXECUTE state.
- Write-back commits at the edge where `wb_valid` is sampled. `ops_valid` falls in the next cycle. A read of the same register in any later phase returns the new value. No bypass is required, because the decoder always spends at least one IDLE cycle between instructions.
- Simultaneous `rs_valid` and `wb_valid` in S_WAIT_WB: the write is committed, the read is ignored, and `protocol_err` is set.
- `reset_n` asserted mid-operation: all state clears immediately and asynchronously. The pending write-back is lost.
- `protocol_err` clears only on reset.

## Test plan
- Reset, then read x5 via an R-type sequence (A=x5, B=x6) -> `op_a` = 0, `op_b` = 0, `ops_valid` = 1 at T+2.
- Preload: A=x0, IMME phase, `rd_addr` = 3, `wb_data` = 0x0000_00AA. Then an R-type with A=x3, B=x0 -> `op_a` = 0x0000_00AA, `op_b` = 0.
- I-type: A=x3 (0xAA), IMME phase with `rs_addr` = 0 -> `op_a` stays 0xAA, `op_b` = 0, `ops_valid` = 1.
- Write-back to `rd` = 0 with 0xDEAD_BEEF, then read x0 -> 0. Also: `rd_addr` changed to 9 during S_WAIT_WB -> the write lands in the latched `rd`, not x9.
- `wb_valid` pulse in S_IDLE -> `protocol_err` = 1 and stays 1; no register changes. `rs_valid && rs_sel` in S_IDLE -> same.
- Assert `reset_n` low during S_WAIT_WB before `wb_valid` -> all outputs 0 within the same cycle, and the previously written x3 reads back 0.

Source files
------------

// File: rtl/reg_file_v1.sv
// reg_file_v1: 32-entry architectural register file serving the decoder's
// two-phase operand-read protocol. It returns operand A, then operand B (or
// zero for the immediate phase), then waits for the ALU write-back and commits
// it to the destination index latched during the operand-A phase.
module reg_file_v1 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      rs_addr,
    input  logic            rs_valid,
    input  logic            rs_sel,
    input  logic            rs_store,
    input  logic [4:0]      rd_addr,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic            ops_valid,
    output logic            mem_op,
    output logic            protocol_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HAVE_A  = 2'd1;
    localparam logic [1:0] S_WAIT_WB = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [4:0]      rd_lat;
    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] rs_rdata;
    logic            cap_a, cap_b, wb_en, err_set;

    // x0 is hardwired to zero on the read side; its storage is never written
    assign rs_rdata = (rs_addr == 5'd0) ? '0 : regs[rs_addr];

    // Operand-A capture only from idle with rs_sel low; operand-B only with rs_sel high.
    // The immediate phase (HAVE_A, rs_sel low) advances the FSM but captures nothing.
    assign cap_a   = (state == S_IDLE)   && rs_valid && !rs_sel;
    assign cap_b   = (state == S_HAVE_A) && rs_valid &&  rs_sel;
    assign wb_en   = (state == S_WAIT_WB) && wb_valid && (rd_lat != 5'd0);
    assign err_set = ((state == S_IDLE)    && rs_valid && rs_sel) ||
                     ((state == S_WAIT_WB) && rs_valid)           ||
                     ((state != S_WAIT_WB) && wb_valid);

    // Next-state decode for the operand/write-back sequence
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (cap_a)    state_nxt = S_HAVE_A;
            S_HAVE_A:  if (rs_valid) state_nxt = S_WAIT_WB;
            S_WAIT_WB: if (wb_valid) state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // State register plus registered ops_valid and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            ops_valid    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            ops_valid <= (state_nxt == S_WAIT_WB);
            if (err_set) protocol_err <= 1'b1;
        end
    end

    // Operand, memory-op tag and destination latches; held until the next A capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a   <= '0;
            op_b   <= '0;
            mem_op <= 1'b0;
            rd_lat <= 5'd0;
        end else if (cap_a) begin
            op_a   <= rs_rdata;
            op_b   <= '0;
            mem_op <= rs_store;
            rd_lat <= rd_addr;
        end else if (cap_b) begin
            op_b   <= rs_rdata;
        end
    end

    // Register storage; write-back only from S_WAIT_WB to a nonzero latched index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[rd_lat] <= wb_data;
        end
    end

endmodule

// File: tb/tb_reg_file_v1.sv
// tb_reg_file_v1: directed and randomized instruction sequences against an
// instruction-level model of the register file (array of 32 words + sticky error).
module tb_reg_file_v1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs_addr, rd_addr;
    logic        rs_valid, rs_sel, rs_store, wb_valid;
    logic [31:0] wb_data;
    logic [31:0] op_a, op_b;
    logic        ops_valid, mem_op, protocol_err;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mref [32];
    logic        exp_err;

    always #5 clk = ~clk;

    reg_file_v1 #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rs_valid(rs_valid),
        .rs_sel(rs_sel), .rs_store(rs_store), .rd_addr(rd_addr),
        .wb_valid(wb_valid), .wb_data(wb_data), .op_a(op_a), .op_b(op_b),
        .ops_valid(ops_valid), .mem_op(mem_op), .protocol_err(protocol_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_valid = 1'b0; rs_sel = 1'b0; rs_addr = 5'd0; rs_store = 1'b0;
        rd_addr = 5'd0; wb_valid = 1'b0; wb_data = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) mref[i] = 32'h0;
        exp_err = 1'b0;
        step();
    endtask

    // One full instruction: A phase, B or immediate phase, optional extra
    // wait cycles, then write-back. Expected values come from the model array.
    task automatic instr(input int a, input int b, input bit imm, input int rd,
                         input bit st, input logic [31:0] d, input int wait_cyc,
                         input int late_rd, input bit rs_with_wb);
        logic [31:0] ea, eb;
        ea = mref[a];
        eb = imm ? 32'h0 : mref[b];
        rs_valid = 1'b1; rs_sel = 1'b0; rs_addr = 5'(a); rd_addr = 5'(rd); rs_store = st;
        step();
        chk("opa_T1", op_a, ea);
        chk("mem_op_T1", {31'h0, mem_op}, {31'h0, st});
        chk("ops_valid_T1", {31'h0, ops_valid}, 32'h0);
        rs_sel = imm ? 1'b0 : 1'b1;
        rs_addr = imm ? 5'd0 : 5'(b);
        rd_addr = 5'(late_rd);
        rs_store = ~st;
        step();
        rs_valid = 1'b0;
        chk("opa_T2", op_a, ea);
        chk("opb_T2", op_b, eb);
        chk("ops_valid_T2", {31'h0, ops_valid}, 32'h1);
        for (int k = 0; k < wait_cyc; k++) begin
            step();
            chk("ops_valid_wait", {31'h0, ops_valid}, 32'h1);
        end
        wb_valid = 1'b1; wb_data = d;
        if (rs_with_wb) begin
            rs_valid = 1'b1; rs_sel = 1'b0; rs_addr = 5'(rd);
        end
        step();
        idle_inputs();
        if (rd != 0) mref[rd] = d;
        if (rs_with_wb) exp_err = 1'b1;
        chk("ops_valid_after_wb", {31'h0, ops_valid}, 32'h0);
        chk("opa_hold", op_a, ea);
        chk("opb_hold", op_b, eb);
        chk("mem_op_hold", {31'h0, mem_op}, {31'h0, st});
        chk("err_after_wb", {31'h0, protocol_err}, {31'h0, exp_err});
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i++) mref[i] = 32'h0;
        exp_err = 1'b0;
        #2;
        chk("rst_opa", op_a, 32'h0);
        chk("rst_opb", op_b, 32'h0);
        chk("rst_ops_valid", {31'h0, ops_valid}, 32'h0);
        chk("rst_mem_op", {31'h0, mem_op}, 32'h0);
        chk("rst_err", {31'h0, protocol_err}, 32'h0);
        do_reset();

        // Read x5/x6 after reset, result discarded to x0
        instr(5, 6, 0, 0, 0, 32'h1234_5678, 0, 0, 0);
        // Preload x3 via immediate instruction
        instr(0, 0, 1, 3, 0, 32'h0000_00AA, 0, 0, 0);
        // R-type A=x3 B=x0, write-back to x0 discarded
        instr(3, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0);
        instr(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("x0_zero", op_a, 32'h0);
        // I-type with A=x3: op_a must survive the rs_addr=0 immediate phase
        instr(3, 0, 1, 8, 0, 32'h5555_0001, 0, 0, 0);
        // rd_addr moves to 9 in later phases; write must land in latched x7
        instr(1, 2, 0, 7, 0, 32'hCAFE_F00D, 2, 9, 0);
        instr(7, 9, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("latched_rd_x7", op_a, 32'hCAFE_F00D);
        chk("x9_untouched", op_b, 32'h0);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            instr(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                  1'($urandom_range(1, 0)), int'($urandom_range(31, 0)),
                  1'($urandom_range(1, 0)), $urandom, int'($urandom_range(2, 0)),
                  int'($urandom_range(31, 0)), 1'b0);
        end
        chk("err_clean_after_random", {31'h0, protocol_err}, 32'h0);

        // Simultaneous read and write-back in S_WAIT_WB: write commits, read ignored
        instr(0, 0, 1, 12, 0, 32'h0BAD_0012, 0, 0, 0);
        instr(12, 0, 1, 12, 0, 32'h7777_1212, 0, 0, 1);
        instr(12, 0, 1, 0, 0, 32'h0, 0, 0, 0);
        chk("sim_rs_wb_write", op_a, 32'h7777_1212);

        // Write-back pulse in S_IDLE: error set, latched x4 not overwritten
        do_reset();
        instr(0, 0, 1, 4, 0, 32'h4444_4444, 0, 0, 0);
        wb_valid = 1'b1; wb_data = 32'hFFFF_FFFF; rd_addr = 5'd4;
        step();
        idle_inputs();
        exp_err = 1'b1;
        chk("err_wb_idle", {31'h0, protocol_err}, 32'h1);
        step();
        chk("err_sticky", {31'h0, protocol_err}, 32'h1);
        instr(4, 0, 1, 0, 0, 32'h0, 0, 0, 0);
        chk("x4_unchanged", op_a, 32'h4444_4444);

        // rs_sel phase in S_IDLE: error set, request ignored, FSM stays idle
        do_reset();
        instr(0, 0, 1, 3, 0, 32'h0000_00AA, 0, 0, 0);
        rs_valid = 1'b1; rs_sel = 1'b1; rs_addr = 5'd3;
        step();
        idle_inputs();
        exp_err = 1'b1;
        chk("err_sel_idle", {31'h0, protocol_err}, 32'h1);
        chk("sel_idle_opb", op_b, 32'h0);
        chk("sel_idle_ops_valid", {31'h0, ops_valid}, 32'h0);
        step();
        instr(3, 3, 0, 0, 0, 32'h0, 0, 0, 0);

        // Asynchronous reset in S_WAIT_WB: outputs clear before the next edge
        rs_valid = 1'b1; rs_sel = 1'b0; rs_addr = 5'd3; rs_store = 1'b1; rd_addr = 5'd3;
        step();
        rs_sel = 1'b1;
        step();
        idle_inputs();
        wb_data = 32'h1111_2222;
        chk("pre_rst_ops_valid", {31'h0, ops_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("arst_opa", op_a, 32'h0);
        chk("arst_opb", op_b, 32'h0);
        chk("arst_ops_valid", {31'h0, ops_valid}, 32'h0);
        chk("arst_mem_op", {31'h0, mem_op}, 32'h0);
        chk("arst_err", {31'h0, protocol_err}, 32'h0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) mref[i] = 32'h0;
        exp_err = 1'b0;
        step();
        instr(3, 0, 1, 0, 0, 32'h0, 0, 0, 0);
        chk("x3_cleared", op_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
